// File: rtl/skid_fifo_struct.sv
// First-word-fall-through elastic buffer with typed payload, flush, occupancy
// and optional zero-latency bypass. ready_in never depends on ready_out.
module skid_fifo_struct #(
   parameter type T            = logic,
   parameter int  DEPTH        = 4,
   parameter int  AFULL_THRESH = DEPTH - 1,
   parameter bit  BYPASS       = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       valid_in,
   output logic                       ready_in,
   input  T                           data_in,
   output logic                       valid_out,
   input  logic                       ready_out,
   output T                           data_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T                mem_r [DEPTH];
   logic [PW-1:0]   rd_ptr_r;
   logic [PW-1:0]   wr_ptr_r;
   logic [CW-1:0]   count_r;
   logic            almost_full_r;

   logic            empty_s;
   logic            full_s;
   logic            bypass_s;
   logic            push_s;
   logic            pop_s;
   logic [PW-1:0]   rd_ptr_nxt_s;
   logic [PW-1:0]   wr_ptr_nxt_s;
   logic [CW-1:0]   count_nxt_s;

   // Handshake, bypass decision and head selection from current state.
   always_comb begin
      empty_s   = (count_r == CW'(0));
      full_s    = (count_r == CW'(DEPTH));
      ready_in  = !flush && !full_s;
      valid_out = !flush && (!empty_s || (BYPASS && valid_in));
      // Bypass only when the item leaves in the same cycle it arrives.
      bypass_s  = BYPASS && empty_s && valid_in && ready_out && !flush;
      push_s    = valid_in && ready_in && !bypass_s;
      pop_s     = valid_out && ready_out && !empty_s;
      if (!empty_s) begin
         data_out = mem_r[rd_ptr_r];
      end else if (BYPASS) begin
         data_out = data_in;
      end else begin
         data_out = mem_r[rd_ptr_r];
      end
   end

   // Next pointer and occupancy values with explicit wrap at DEPTH-1.
   always_comb begin
      rd_ptr_nxt_s = rd_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      count_nxt_s  = count_r;
      if (push_s) begin
         if (wr_ptr_r == PW'(DEPTH - 1)) begin
            wr_ptr_nxt_s = PW'(0);
         end else begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
         end
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         if (rd_ptr_r == PW'(DEPTH - 1)) begin
            rd_ptr_nxt_s = PW'(0);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
         end
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer, occupancy and almost-full registers; flush squashes to empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r      <= PW'(0);
         wr_ptr_r      <= PW'(0);
         count_r       <= CW'(0);
         almost_full_r <= 1'b0;
      end else if (flush) begin
         rd_ptr_r      <= PW'(0);
         wr_ptr_r      <= PW'(0);
         count_r       <= CW'(0);
         almost_full_r <= 1'b0;
      end else begin
         rd_ptr_r      <= rd_ptr_nxt_s;
         wr_ptr_r      <= wr_ptr_nxt_s;
         count_r       <= count_nxt_s;
         almost_full_r <= (count_nxt_s >= CW'(AFULL_THRESH));
      end
   end

   // Payload storage; flush leaves contents in place.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   assign count       = count_r;
   assign almost_full = almost_full_r;

endmodule

// File: tb/tb_skid_fifo_struct.sv
// Directed bench for skid_fifo_struct: three instances cover the default
// configuration, a non-power-of-two depth and the bypass variant.
module tb_skid_fifo_struct;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   // DEPTH=4, BYPASS=0
   logic       a_flush, a_vin, a_rin, a_vout, a_rout, a_af;
   logic [7:0] a_din, a_dout;
   logic [2:0] a_cnt;
   // DEPTH=3, BYPASS=0
   logic       c_flush, c_vin, c_rin, c_vout, c_rout, c_af;
   logic [7:0] c_din, c_dout;
   logic [1:0] c_cnt;
   // DEPTH=4, BYPASS=1
   logic       b_flush, b_vin, b_rin, b_vout, b_rout, b_af;
   logic [7:0] b_din, b_dout;
   logic [2:0] b_cnt;

   skid_fifo_struct #(.T(logic [7:0]), .DEPTH(4), .BYPASS(1'b0)) u_dut_a (
      .clk(clk), .reset(reset), .flush(a_flush),
      .valid_in(a_vin), .ready_in(a_rin), .data_in(a_din),
      .valid_out(a_vout), .ready_out(a_rout), .data_out(a_dout),
      .count(a_cnt), .almost_full(a_af));

   skid_fifo_struct #(.T(logic [7:0]), .DEPTH(3), .BYPASS(1'b0)) u_dut_c (
      .clk(clk), .reset(reset), .flush(c_flush),
      .valid_in(c_vin), .ready_in(c_rin), .data_in(c_din),
      .valid_out(c_vout), .ready_out(c_rout), .data_out(c_dout),
      .count(c_cnt), .almost_full(c_af));

   skid_fifo_struct #(.T(logic [7:0]), .DEPTH(4), .BYPASS(1'b1)) u_dut_b (
      .clk(clk), .reset(reset), .flush(b_flush),
      .valid_in(b_vin), .ready_in(b_rin), .data_in(b_din),
      .valid_out(b_vout), .ready_out(b_rout), .data_out(b_dout),
      .count(b_cnt), .almost_full(b_af));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_cnt); end
      n_checks++; if (a_vout !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b want 0", a_vout); end
      n_checks++; if (a_rin !== 1'b1) begin n_fail++; $display("FAIL reset_ready_in: got %b want 1", a_rin); end
      n_checks++; if (a_af !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", a_af); end
      n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", a_dout); end
      @(negedge clk);
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_fill_drain();
      logic [7:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      a_rout = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_vin = 1'b1; a_din = vals[i];
         #4;
         n_checks++; if (a_rin !== 1'b1) begin n_fail++; $display("FAIL fill_ready_in[%0d]: got %b want 1", i, a_rin); end
         cyc();
         n_checks++; if (a_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_cnt, i + 1); end
         n_checks++; if (a_af !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, a_af, (i + 1 >= 3)); end
      end
      a_vin = 1'b0;
      #4;
      n_checks++; if (a_rin !== 1'b0) begin n_fail++; $display("FAIL full_ready_in: got %b want 0", a_rin); end
      cyc();
      a_rout = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #4;
         n_checks++; if (a_vout !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, a_vout); end
         n_checks++; if (a_dout !== vals[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, a_dout, vals[i]); end
         cyc();
      end
      a_rout = 1'b0;
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", a_cnt); end
      n_checks++; if (a_vout !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end: got %b want 0", a_vout); end
   endtask

   task automatic test_full_simultaneous();
      logic [7:0] vals [4];
      vals[0] = 8'h66; vals[1] = 8'h77; vals[2] = 8'h88; vals[3] = 8'h99;
      a_rout = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_vin = 1'b1; a_din = vals[i]; cyc();
      end
      a_din = 8'h5A; cyc();
      // full: producer offers 0x99 while the consumer pops
      a_din = 8'h99; a_rout = 1'b1;
      #4;
      n_checks++; if (a_rin !== 1'b0) begin n_fail++; $display("FAIL fullsim_ready_in: got %b want 0", a_rin); end
      n_checks++; if (a_dout !== 8'h66) begin n_fail++; $display("FAIL fullsim_head: got %h want 66", a_dout); end
      cyc();
      n_checks++; if (a_cnt !== 3'd3) begin n_fail++; $display("FAIL fullsim_count: got %0d want 3", a_cnt); end
      a_rout = 1'b0;
      cyc();
      a_vin = 1'b0; a_rout = 1'b1;
      vals[2] = 8'h5A; vals[3] = 8'h99;
      vals[0] = 8'h77; vals[1] = 8'h88;
      for (int i = 0; i < 4; i++) begin
         #4;
         n_checks++; if (a_dout !== vals[i]) begin n_fail++; $display("FAIL fullsim_order[%0d]: got %h want %h", i, a_dout, vals[i]); end
         cyc();
      end
      a_rout = 1'b0;
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL fullsim_empty: got %0d want 0", a_cnt); end
   endtask

   task automatic test_flush();
      a_rout = 1'b0;
      a_vin = 1'b1; a_din = 8'hA1; cyc();
      a_din = 8'hA2; cyc();
      a_flush = 1'b1; a_din = 8'hA3; a_rout = 1'b1;
      #4;
      n_checks++; if (a_vout !== 1'b0) begin n_fail++; $display("FAIL flush_valid_out: got %b want 0", a_vout); end
      n_checks++; if (a_rin !== 1'b0) begin n_fail++; $display("FAIL flush_ready_in: got %b want 0", a_rin); end
      cyc();
      a_flush = 1'b0; a_rout = 1'b0;
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", a_cnt); end
      a_din = 8'hB1; cyc();
      a_vin = 1'b0;
      #4;
      n_checks++; if (a_dout !== 8'hB1) begin n_fail++; $display("FAIL flush_first_after: got %h want b1", a_dout); end
      n_checks++; if (a_cnt !== 3'd1) begin n_fail++; $display("FAIL flush_count_after: got %0d want 1", a_cnt); end
      cyc();
      a_rout = 1'b1; cyc();
      a_rout = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] vin_pat;
      logic [15:0] rout_pat;
      int sent, recv, model, k;
      logic push, pop;
      vin_pat  = 16'b1111_0111_1101_1111;
      rout_pat = 16'b0101_0011_1000_0110;
      sent = 0; recv = 0; model = 0; k = 0;
      while (recv < 10 && k < 300) begin
         c_vin  = (sent < 10) && vin_pat[k % 16];
         c_din  = 8'(sent);
         c_rout = rout_pat[(k * 3) % 16];
         #4;
         n_checks++; if (c_cnt !== 2'(model)) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, c_cnt, model); end
         n_checks++; if (c_rin !== (model != 3)) begin n_fail++; $display("FAIL wrap_ready_in[%0d]: got %b want %b", k, c_rin, (model != 3)); end
         n_checks++; if (c_vout !== (model != 0)) begin n_fail++; $display("FAIL wrap_valid_out[%0d]: got %b want %b", k, c_vout, (model != 0)); end
         push = c_vin && (model != 3);
         pop  = c_rout && (model != 0);
         if (pop) begin
            n_checks++; if (c_dout !== 8'(recv)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d want %0d", k, c_dout, recv); end
            recv++;
         end
         if (push) sent++;
         model = model + (push ? 1 : 0) - (pop ? 1 : 0);
         cyc();
         k++;
      end
      c_vin = 1'b0; c_rout = 1'b0;
      n_checks++; if (recv != 10) begin n_fail++; $display("FAIL wrap_timeout: received %0d want 10", recv); end
   endtask

   task automatic test_bypass();
      b_vin = 1'b1; b_din = 8'hAB; b_rout = 1'b1;
      #4;
      n_checks++; if (b_vout !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", b_vout); end
      n_checks++; if (b_dout !== 8'hAB) begin n_fail++; $display("FAIL bypass_data: got %h want ab", b_dout); end
      cyc();
      n_checks++; if (b_cnt !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", b_cnt); end
      b_rout = 1'b0;
      cyc();
      b_vin = 1'b0; b_din = 8'h00;
      #4;
      n_checks++; if (b_cnt !== 3'd1) begin n_fail++; $display("FAIL bypass_held_count: got %0d want 1", b_cnt); end
      n_checks++; if (b_dout !== 8'hAB) begin n_fail++; $display("FAIL bypass_held_data: got %h want ab", b_dout); end
      n_checks++; if (b_vout !== 1'b1) begin n_fail++; $display("FAIL bypass_held_valid: got %b want 1", b_vout); end
      cyc();
      b_rout = 1'b1; cyc();
      b_rout = 1'b0;
      n_checks++; if (b_cnt !== 3'd0) begin n_fail++; $display("FAIL bypass_drain_count: got %0d want 0", b_cnt); end
   endtask

   task automatic test_reset_midstream();
      a_rout = 1'b0;
      a_vin = 1'b1; a_din = 8'h01; cyc();
      a_din = 8'h02; cyc();
      a_din = 8'h03; cyc();
      n_checks++; if (a_af !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_af: got %b want 1", a_af); end
      a_din = 8'h04; b_vin = 1'b0; b_din = 8'h5C;
      #3;
      reset = 1'b0;
      #1;
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", a_cnt); end
      n_checks++; if (a_vout !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_out: got %b want 0", a_vout); end
      n_checks++; if (a_af !== 1'b0) begin n_fail++; $display("FAIL midrst_almost_full: got %b want 0", a_af); end
      n_checks++; if (a_rin !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_in: got %b want 1", a_rin); end
      n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h want 00", a_dout); end
      n_checks++; if (b_dout !== 8'h5C) begin n_fail++; $display("FAIL midrst_bypass_data: got %h want 5c", b_dout); end
      #2;
      reset = 1'b1;
      cyc();
      a_vin = 1'b0;
      n_checks++; if (a_cnt !== 3'd1) begin n_fail++; $display("FAIL postrst_count: got %0d want 1", a_cnt); end
      n_checks++; if (a_dout !== 8'h04) begin n_fail++; $display("FAIL postrst_data: got %h want 04", a_dout); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b0;
      a_flush = 1'b0; a_vin = 1'b0; a_rout = 1'b0; a_din = 8'h00;
      c_flush = 1'b0; c_vin = 1'b0; c_rout = 1'b0; c_din = 8'h00;
      b_flush = 1'b0; b_vin = 1'b0; b_rout = 1'b0; b_din = 8'h00;
      test_reset();
      test_fill_drain();
      test_full_simultaneous();
      test_flush();
      test_wrap();
      test_bypass();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
